// File: rtl/a5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : a5_pkg
// Description : Shared types and constants for the A5/1 session sequencer:
//               FSM state encoding, LFSR geometry and default session sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package a5_pkg;

    // Session state encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        KEY    = 3'd2,
        FRAME  = 3'd3,
        MIX    = 3'd4,
        STREAM = 3'd5,
        DONE   = 3'd6
    } state_t;

    // LFSR lengths
    localparam int c_R1_LEN = 19;
    localparam int c_R2_LEN = 22;
    localparam int c_R3_LEN = 23;

    // Clocking (sync) bit positions
    localparam int c_R1_SYNC = 8;
    localparam int c_R2_SYNC = 10;
    localparam int c_R3_SYNC = 10;

    // Feedback tap masks
    localparam logic [c_R1_LEN-1:0] c_R1_TAPS = 19'h7_2000;
    localparam logic [c_R2_LEN-1:0] c_R2_TAPS = 22'h30_0000;
    localparam logic [c_R3_LEN-1:0] c_R3_TAPS = 23'h70_0080;

    // Default session sizes
    localparam int c_DEF_KEYLEN      = 64;
    localparam int c_DEF_FRAMENUMLEN = 22;
    localparam int c_DEF_MIXCYCLES   = 100;
    localparam int c_DEF_STREAMLEN   = 228;

    // Three-input majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Larger of two integers, used to size counters
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/a5_majority.sv
`default_nettype none
// ============================================================================
// Module      : a5_majority
// Description : Majority clocking rule. A register steps when its clocking
//               bit agrees with the majority of the three clocking bits.
// Revision    : 1.0 - initial release
// ============================================================================
module a5_majority
    import a5_pkg::*;
(
    input  logic [2:0] sync,
    input  logic       en,
    output logic [2:0] step
);

    logic w_maj;

    // Step every register whose clocking bit matches the majority
    always_comb begin
        w_maj = maj3(sync[0], sync[1], sync[2]);
        step  = 3'b000;
        if (en) begin
            step = ~(sync ^ {3{w_maj}});
        end
    end

endmodule
`default_nettype wire

// File: rtl/a5_session_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : a5_session_sequencer
// Description : Sequences one A5/1 keystream session (clear, key load, frame
//               load, mixing, keystream delivery) over three external
//               majority-clocked LFSRs, delivering ks_bit via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module a5_session_sequencer
    import a5_pkg::*;
#(
    parameter int KEYLEN      = c_DEF_KEYLEN,
    parameter int FRAMENUMLEN = c_DEF_FRAMENUMLEN,
    parameter int MIXCYCLES   = c_DEF_MIXCYCLES,
    parameter int STREAMLEN   = c_DEF_STREAMLEN
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEYLEN-1:0]      key,
    input  logic [FRAMENUMLEN-1:0] frame,
    input  logic                   ready,
    input  logic [2:0]             sync,
    input  logic [2:0]             exposed,
    output logic                   clear,
    output logic                   load_en,
    output logic                   load_bit,
    output logic [2:0]             step,
    output logic                   ks_bit,
    output logic                   ks_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int c_CNT_W = $clog2(max2(max2(KEYLEN, FRAMENUMLEN),
                                         max2(MIXCYCLES, STREAMLEN)));

    localparam logic [c_CNT_W-1:0] c_KEY_LAST    = c_CNT_W'(KEYLEN - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST  = c_CNT_W'(FRAMENUMLEN - 1);
    localparam logic [c_CNT_W-1:0] c_MIX_LAST    = c_CNT_W'(MIXCYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STREAM_LAST = c_CNT_W'(STREAMLEN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     w_count_nxt;
    logic [KEYLEN-1:0]      r_key_sh;
    logic [FRAMENUMLEN-1:0] r_frame_sh;
    logic                   w_key_bit;
    logic                   w_frame_bit;
    logic                   w_xfer;
    logic                   w_maj_en;
    logic [2:0]             w_maj_step;

    // Shift-and-truncate selects the current bit without an oversized index
    assign w_key_bit   = 1'(r_key_sh >> r_count);
    assign w_frame_bit = 1'(r_frame_sh >> r_count);

    // Registers move only in MIX or on an accepted keystream transfer
    assign w_xfer   = (r_state == STREAM) && ready;
    assign w_maj_en = (r_state == MIX) || w_xfer;

    a5_majority u_majority (
        .sync (sync),
        .en   (w_maj_en),
        .step (w_maj_step)
    );

    // State and shared phase counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Shadow copies of key and frame, taken only when a session is accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_key_sh   <= '0;
            r_frame_sh <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_key_sh   <= key;
            r_frame_sh <= frame;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        clear       = 1'b0;
        load_en     = 1'b0;
        load_bit    = 1'b0;
        step        = 3'b000;
        ks_bit      = 1'b0;
        ks_valid    = 1'b0;
        done        = 1'b0;
        busy        = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                if (start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clear       = 1'b1;
                w_state_nxt = KEY;
            end
            KEY: begin
                load_en  = 1'b1;
                load_bit = w_key_bit;
                step     = 3'b111;
                if (r_count == c_KEY_LAST) begin
                    w_count_nxt = '0;
                    w_state_nxt = FRAME;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            FRAME: begin
                load_en  = 1'b1;
                load_bit = w_frame_bit;
                step     = 3'b111;
                if (r_count == c_FRAME_LAST) begin
                    w_count_nxt = '0;
                    w_state_nxt = MIX;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            MIX: begin
                step = w_maj_step;
                if (r_count == c_MIX_LAST) begin
                    w_count_nxt = '0;
                    w_state_nxt = STREAM;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            STREAM: begin
                ks_valid = 1'b1;
                ks_bit   = ^exposed;
                step     = w_maj_step;
                if (ready) begin
                    if (r_count == c_STREAM_LAST) begin
                        w_count_nxt = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
